ifc_initiator: RTL and testbench

//  Transaction initiator for the 8-entry x 1-bit write/read method interface of the dut memory.
//  - Accepts one command at a time on a valid/ready port.
//  - Sequences write_en/read_en strictly under the target's write_rdy/read_rdy.
//  - Captures read_data and returns it on a valid/ready response port.
//  - Sits between test/control logic and the dut, which it drives as the initiating end.

---
 rtl/ifc_initiator.sv | 150 +++++++++++++++
 tb/tb_ifc_initiator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifc_initiator.sv
// ifc_initiator: one-at-a-time valid/ready command initiator driving a write/read method interface.
// Optional rdy-wait abort enabled by defining IFC_INIT_TIMEOUT_EN.
module ifc_initiator #(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 1,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    output logic              write_en,
    input  logic              write_rdy,
    output logic [ADDR_W-1:0] read_address,
    output logic              read_en,
    input  logic [DATA_W-1:0] read_data,
    input  logic              read_rdy
);

    typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;

`ifdef IFC_INIT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timed_out;

    // Last low-rdy cycle before the counter would reach TIMEOUT.
    assign timed_out = (cnt_q == CNT_LAST);
`else
    logic                timeout_unused;
    assign timeout_unused = (TIMEOUT > 0);
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
`ifdef IFC_INIT_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        write_en   = 1'b0;
        read_en    = 1'b0;

        case (state_q)
            IDLE: begin
                // Gated so the port reads not-ready while reset is held.
                cmd_ready = RST_N;
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    data_d  = cmd_data;
                    state_d = cmd_write ? WR : RD;
`ifdef IFC_INIT_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WR: begin
                write_en = write_rdy;
                if (write_rdy) begin
                    state_d = IDLE;
                end
`ifdef IFC_INIT_TIMEOUT_EN
                else if (timed_out) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RSP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RD: begin
                read_en = read_rdy;
                if (read_rdy) begin
                    rsp_data_d = read_data;
                    rsp_err_d  = 1'b0;
                    state_d    = RSP;
                end
`ifdef IFC_INIT_TIMEOUT_EN
                else if (timed_out) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RSP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
`ifdef IFC_INIT_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
`ifdef IFC_INIT_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign busy          = (state_q != IDLE);
    assign rsp_data      = rsp_data_q;
    assign rsp_err       = rsp_err_q;
    assign write_address = addr_q;
    assign write_data    = data_q;
    assign read_address  = addr_q;

endmodule

// File: tb/tb_ifc_initiator.sv
// Bench for ifc_initiator: directed steps plus randomized traffic against an 8x1 target memory,
// with expected read data taken from a command-level memory model.
module tb_ifc_initiator;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [2:0] cmd_addr = '0;
    logic [0:0] cmd_data = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [0:0] rsp_data;
    logic       rsp_err;
    logic       busy;
    logic [2:0] write_address;
    logic [0:0] write_data;
    logic       write_en;
    logic       write_rdy = 1'b0;
    logic [2:0] read_address;
    logic       read_en;
    logic [0:0] read_data;
    logic       read_rdy = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic mem_clr = 1'b1;
    logic tgt_mem [8];
    bit   exp_mem [8];

    ifc_initiator #(.ADDR_W(3), .DATA_W(1), .TIMEOUT(16)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy),
        .write_address(write_address), .write_data(write_data), .write_en(write_en),
        .write_rdy(write_rdy),
        .read_address(read_address), .read_en(read_en), .read_data(read_data),
        .read_rdy(read_rdy)
    );

    always #5 CLK = ~CLK;

    // Target memory: writes land on the clock edge, reads are combinational.
    always @(posedge CLK) begin
        if (mem_clr) begin
            for (int i = 0; i < 8; i++) tgt_mem[i] <= 1'b0;
        end else if (write_en) begin
            tgt_mem[write_address] <= write_data[0];
        end
    end
    assign read_data[0] = tgt_mem[read_address];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one command from IDLE, inserts rdy_dly low-rdy cycles, holds the response rsp_hold cycles.
    task automatic run_cmd(input bit wr, input logic [2:0] a, input logic d,
                           input int rdy_dly, input int rsp_hold);
        logic exp_rd;
        exp_rd = 1'b0;
        check("idle_cmd_ready", 32'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_data = d;
        write_rdy = 1'b0; read_rdy = 1'b0;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom); cmd_addr = 3'($urandom); cmd_data = 1'($urandom);
        check("busy_after_accept", 32'(busy), 1);
        check("cmd_ready_busy", 32'(cmd_ready), 0);
        for (int i = 0; i < rdy_dly; i++) begin
            #1;
            check("wr_en_wait", 32'(write_en), 0);
            check("rd_en_wait", 32'(read_en), 0);
            @(posedge CLK); #1;
        end
        if (wr) write_rdy = 1'b1; else read_rdy = 1'b1;
        #1;
        if (wr) begin
            check("wr_en_fire", 32'(write_en), 1);
            check("rd_en_during_wr", 32'(read_en), 0);
            check("wr_addr", 32'(write_address), 32'(a));
            check("wr_data", 32'(write_data), 32'(d));
        end else begin
            exp_rd = exp_mem[a];
            check("rd_en_fire", 32'(read_en), 1);
            check("wr_en_during_rd", 32'(write_en), 0);
            check("rd_addr", 32'(read_address), 32'(a));
        end
        @(posedge CLK); #1;
        if (wr) begin
            exp_mem[a] = d;
            check("wr_en_one_cycle", 32'(write_en), 0);
            check("cmd_ready_after_wr", 32'(cmd_ready), 1);
            check("busy_after_wr", 32'(busy), 0);
            check("no_rsp_for_wr", 32'(rsp_valid), 0);
            write_rdy = 1'b0;
        end else begin
            check("rd_en_one_cycle", 32'(read_en), 0);
            read_rdy = 1'b0;
            check("rsp_valid", 32'(rsp_valid), 1);
            check("rsp_data", 32'(rsp_data), 32'(exp_rd));
            check("rsp_err", 32'(rsp_err), 0);
            check("cmd_ready_in_rsp", 32'(cmd_ready), 0);
            for (int i = 0; i < rsp_hold; i++) begin
                @(posedge CLK); #1;
                check("rsp_hold_valid", 32'(rsp_valid), 1);
                check("rsp_hold_data", 32'(rsp_data), 32'(exp_rd));
                check("rsp_hold_cmd_ready", 32'(cmd_ready), 0);
            end
            rsp_ready = 1'b1;
            @(posedge CLK); #1;
            rsp_ready = 1'b0;
            check("rsp_done_valid", 32'(rsp_valid), 0);
            check("rsp_done_cmd_ready", 32'(cmd_ready), 1);
        end
    endtask

    initial begin
        int  k;
        bit  en_seen;
        bit  rw;
        logic [2:0] ra;
        logic rd;

        for (int i = 0; i < 8; i++) exp_mem[i] = 1'b0;

        // Reset with rdy and cmd_valid asserted to show outputs are forced off.
        write_rdy = 1'b1; read_rdy = 1'b1; cmd_valid = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_write_en", 32'(write_en), 0);
        check("rst_read_en", 32'(read_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_write_address", 32'(write_address), 0);
        cmd_valid = 1'b0; write_rdy = 1'b0; read_rdy = 1'b0;
        RST_N = 1'b1;
        mem_clr = 1'b0;
        @(posedge CLK); #1;

        // Write addr 5 data 1 with rdy already available.
        run_cmd(1'b1, 3'd5, 1'b1, 0, 0);
        // Write then read back addr 3, response held 3 cycles.
        run_cmd(1'b1, 3'd3, 1'b1, 0, 0);
        run_cmd(1'b0, 3'd3, 1'b0, 0, 3);
        // Read with read_rdy low for 4 cycles.
        run_cmd(1'b0, 3'd5, 1'b0, 4, 0);

`ifdef IFC_INIT_TIMEOUT_EN
        check("to_cmd_ready", 32'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd4; cmd_data = 1'b1; write_rdy = 1'b0;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        k = 0; en_seen = 1'b0;
        while (!rsp_valid && k < 40) begin
            if (write_en) en_seen = 1'b1;
            @(posedge CLK); #1;
            k++;
        end
        check("to_cycles", 32'(k), 16);
        check("to_no_write_en", 32'(en_seen), 0);
        check("to_rsp_err", 32'(rsp_err), 1);
        check("to_rsp_data", 32'(rsp_data), 0);
        rsp_ready = 1'b1;
        @(posedge CLK); #1;
        rsp_ready = 1'b0;
        check("to_rsp_done", 32'(rsp_valid), 0);
        run_cmd(1'b0, 3'd4, 1'b0, 0, 0);
`else
        k = 0;
        run_cmd(1'b1, 3'd2, 1'b1, 30, 0);
        run_cmd(1'b0, 3'd2, 1'b0, 0, 0);
`endif

        // Reset while waiting in RD with read_rdy low.
        check("mid_cmd_ready", 32'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd6;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        @(posedge CLK); #1;
        check("mid_busy_before", 32'(busy), 1);
        RST_N = 1'b0; read_rdy = 1'b1; write_rdy = 1'b1;
        #1;
        check("mid_rst_read_en", 32'(read_en), 0);
        check("mid_rst_write_en", 32'(write_en), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        check("mid_rst_read_address", 32'(read_address), 0);
        @(posedge CLK); #1;
        check("mid_rst_cmd_ready2", 32'(cmd_ready), 0);
        read_rdy = 1'b0; write_rdy = 1'b0;
        RST_N = 1'b1;
        #1;
        run_cmd(1'b1, 3'd0, 1'b1, 0, 0);
        run_cmd(1'b0, 3'd0, 1'b0, 1, 1);

        // Randomized traffic.
        for (int n = 0; n < 24; n++) begin
            rw = 1'($urandom);
            ra = 3'($urandom);
            rd = 1'($urandom);
            run_cmd(rw, ra, rd, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
        end
        for (int a = 0; a < 8; a++) begin
            run_cmd(1'b0, 3'(a), 1'b0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
